// File: rtl/crossbar_rr_if.sv
// crossbar_rr_if: request, bank and response signals of the banked-memory
// crossbar, bundled so the crossbar sees them through one modport.
//   DMA side   : t_addr/t_data/t_we/t_valid -> t_ready
//   response   : i_dma_out_data/i_dma_out_valid <- i_dma_out_ready
//   bank side  : i_addr/i_data/i_we/i_valid -> i_ready, t_mem_data
//   statistics : perf_stall
// modport slave is the crossbar; modport master is whatever surrounds it.
interface crossbar_rr_if #(
  parameter int unsigned INPUTS      = 4,
  parameter int unsigned BANKS       = 32,
  parameter int unsigned IADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH  = 32
);
  localparam int unsigned BANK_BITS   = $clog2(BANKS);
  localparam int unsigned OADDR_WIDTH = IADDR_WIDTH - BANK_BITS;

  logic [IADDR_WIDTH-1:0] t_addr          [INPUTS];
  logic [DATA_WIDTH-1:0]  t_data          [INPUTS];
  logic                   t_we            [INPUTS];
  logic                   t_valid         [INPUTS];
  logic                   t_ready         [INPUTS];
  logic [DATA_WIDTH-1:0]  i_dma_out_data  [INPUTS];
  logic                   i_dma_out_valid [INPUTS];
  logic                   i_dma_out_ready [INPUTS];
  logic [OADDR_WIDTH-1:0] i_addr          [BANKS];
  logic [DATA_WIDTH-1:0]  i_data          [BANKS];
  logic                   i_we            [BANKS];
  logic                   i_valid         [BANKS];
  logic                   i_ready         [BANKS];
  logic [DATA_WIDTH-1:0]  t_mem_data      [BANKS];
  logic [31:0]            perf_stall      [INPUTS];

  modport slave (
    input  t_addr, t_data, t_we, t_valid, i_dma_out_ready, i_ready, t_mem_data,
    output t_ready, i_dma_out_data, i_dma_out_valid, i_addr, i_data, i_we, i_valid,
    output perf_stall
  );

  modport master (
    output t_addr, t_data, t_we, t_valid, i_dma_out_ready, i_ready, t_mem_data,
    input  t_ready, i_dma_out_data, i_dma_out_valid, i_addr, i_data, i_we, i_valid,
    input  perf_stall
  );
endinterface

// File: rtl/crossbar_rr.sv
// crossbar_rr: connects INPUTS DMA request ports to BANKS single-port memory
// banks. Low address bits pick the bank, upper bits are the row. Each bank
// grants round-robin among eligible inputs. Reads return through per-input
// response FIFOs guarded by credits, so a stalled reader never loses data.
// Ports:
//   clk  - clock
//   srst - synchronous active-high reset
//   bus  - crossbar_rr_if.slave (request, bank, response and perf signals)
// Optional feature: define CROSSBAR_RR_PERF_EN to build the saturating
// per-input stall counters on perf_stall; otherwise perf_stall is tied to 0.
module crossbar_rr #(
  parameter int unsigned INPUTS        = 4,
  parameter int unsigned BANKS         = 32,
  parameter int unsigned IADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MEM_LATENCY   = 1,
  parameter int unsigned RD_FIFO_DEPTH = 4
) (
  input logic          clk,
  input logic          srst,
  crossbar_rr_if.slave bus
);
  localparam int unsigned BANK_BITS = $clog2(BANKS);
  localparam int unsigned PTR_W     = (INPUTS > 1) ? $clog2(INPUTS) : 1;
  localparam int unsigned CRED_W    = $clog2(RD_FIFO_DEPTH + 1);
  localparam int unsigned FPTR_W    = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;

  logic [BANK_BITS-1:0]  req_bank   [INPUTS];
  logic                  elig       [INPUTS];
  logic                  t_ready_i  [INPUTS];
  logic                  rd_accept  [INPUTS];
  logic                  push       [INPUTS];
  logic [DATA_WIDTH-1:0] push_data  [INPUTS];
  logic                  pop        [INPUTS];

  logic [PTR_W-1:0]      rr_ptr     [BANKS];
  logic [PTR_W-1:0]      rr_next    [BANKS];
  logic [PTR_W-1:0]      grant_idx  [BANKS];
  logic                  bank_req   [BANKS];
  logic                  bank_valid [BANKS];

  logic [CRED_W-1:0]     credit     [INPUTS];
  logic                  dl_valid   [INPUTS][MEM_LATENCY];
  logic [BANK_BITS-1:0]  dl_bank    [INPUTS][MEM_LATENCY];
  logic [DATA_WIDTH-1:0] fifo_mem   [INPUTS][RD_FIFO_DEPTH];
  logic [FPTR_W-1:0]     wr_ptr     [INPUTS];
  logic [FPTR_W-1:0]     rd_ptr     [INPUTS];
  logic [CRED_W-1:0]     fifo_cnt   [INPUTS];
  logic [DATA_WIDTH-1:0] last_data  [INPUTS];

  function automatic logic [FPTR_W-1:0] fptr_inc(input logic [FPTR_W-1:0] p);
    return (p == FPTR_W'(RD_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reads need a free credit (registered value, no pop bypass); writes never do.
  always_comb begin
    for (int unsigned j = 0; j < INPUTS; j++) begin
      req_bank[j] = bus.t_addr[j][BANK_BITS-1:0];
      elig[j]     = bus.t_valid[j] && (bus.t_we[j] || (credit[j] < CRED_W'(RD_FIFO_DEPTH)));
    end
  end

  // Per-bank cyclic scan starting at rr_ptr: first eligible requester wins.
  always_comb begin
    int unsigned idx;
    idx = 0;
    for (int unsigned b = 0; b < BANKS; b++) begin
      bank_req[b]  = 1'b0;
      grant_idx[b] = '0;
      for (int unsigned k = 0; k < INPUTS; k++) begin
        idx = (32'(rr_ptr[b]) + k) % INPUTS;
        if (!bank_req[b] && elig[idx] && (req_bank[idx] == BANK_BITS'(b))) begin
          bank_req[b]  = 1'b1;
          grant_idx[b] = PTR_W'(idx);
        end
      end
    end
  end

  always_comb begin
    for (int unsigned b = 0; b < BANKS; b++) begin
      bank_valid[b]  = bank_req[b] && !srst;
      bus.i_valid[b] = bank_valid[b];
      bus.i_addr[b]  = '0;
      bus.i_data[b]  = '0;
      bus.i_we[b]    = 1'b0;
      rr_next[b]     = rr_ptr[b];
      if (bank_valid[b]) begin
        bus.i_addr[b] = bus.t_addr[grant_idx[b]][IADDR_WIDTH-1:BANK_BITS];
        bus.i_data[b] = bus.t_data[grant_idx[b]];
        bus.i_we[b]   = bus.t_we[grant_idx[b]];
        rr_next[b]    = (grant_idx[b] == PTR_W'(INPUTS - 1)) ? '0 : grant_idx[b] + 1'b1;
      end
    end
  end

  // Each input targets exactly one bank, so it can only be granted there.
  always_comb begin
    for (int unsigned j = 0; j < INPUTS; j++) begin
      t_ready_i[j] = elig[j] && bank_valid[req_bank[j]] &&
                     (grant_idx[req_bank[j]] == PTR_W'(j)) && bus.i_ready[req_bank[j]];
      bus.t_ready[j] = t_ready_i[j];
      rd_accept[j]   = t_ready_i[j] && !bus.t_we[j];
      push[j]        = dl_valid[j][MEM_LATENCY-1];
      push_data[j]   = bus.t_mem_data[dl_bank[j][MEM_LATENCY-1]];
      pop[j]         = (fifo_cnt[j] != '0) && bus.i_dma_out_ready[j];
      bus.i_dma_out_valid[j] = (fifo_cnt[j] != '0);
      bus.i_dma_out_data[j]  = (fifo_cnt[j] != '0) ? fifo_mem[j][rd_ptr[j]] : last_data[j];
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < BANKS; b++) begin
      if (srst) begin
        rr_ptr[b] <= '0;
      end else if (bank_valid[b] && bus.i_ready[b]) begin
        rr_ptr[b] <= rr_next[b];
      end
    end
  end

  // Delay line models the fixed memory latency; its last stage marks the
  // cycle in which t_mem_data belongs to this input.
  always_ff @(posedge clk) begin
    for (int unsigned j = 0; j < INPUTS; j++) begin
      dl_bank[j][0] <= req_bank[j];
      for (int unsigned s = 1; s < MEM_LATENCY; s++) begin
        dl_bank[j][s] <= dl_bank[j][s-1];
      end
      if (srst) begin
        for (int unsigned s = 0; s < MEM_LATENCY; s++) begin
          dl_valid[j][s] <= 1'b0;
        end
      end else begin
        dl_valid[j][0] <= rd_accept[j];
        for (int unsigned s = 1; s < MEM_LATENCY; s++) begin
          dl_valid[j][s] <= dl_valid[j][s-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned j = 0; j < INPUTS; j++) begin
      if (srst) begin
        wr_ptr[j]    <= '0;
        rd_ptr[j]    <= '0;
        fifo_cnt[j]  <= '0;
        credit[j]    <= '0;
        last_data[j] <= '0;
      end else begin
        if (push[j]) begin
          fifo_mem[j][wr_ptr[j]] <= push_data[j];
          wr_ptr[j]              <= fptr_inc(wr_ptr[j]);
        end
        if (pop[j]) begin
          rd_ptr[j]    <= fptr_inc(rd_ptr[j]);
          last_data[j] <= fifo_mem[j][rd_ptr[j]];
        end
        case ({push[j], pop[j]})
          2'b10:   fifo_cnt[j] <= fifo_cnt[j] + 1'b1;
          2'b01:   fifo_cnt[j] <= fifo_cnt[j] - 1'b1;
          default: fifo_cnt[j] <= fifo_cnt[j];
        endcase
        case ({rd_accept[j], pop[j]})
          2'b10:   credit[j] <= credit[j] + 1'b1;
          2'b01:   credit[j] <= credit[j] - 1'b1;
          default: credit[j] <= credit[j];
        endcase
      end
    end
  end

`ifdef CROSSBAR_RR_PERF_EN
  logic [31:0] perf_cnt [INPUTS];

  always_ff @(posedge clk) begin
    for (int unsigned j = 0; j < INPUTS; j++) begin
      if (srst) begin
        perf_cnt[j] <= '0;
      end else if (bus.t_valid[j] && !t_ready_i[j] && (perf_cnt[j] != '1)) begin
        perf_cnt[j] <= perf_cnt[j] + 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < INPUTS; j++) begin
      bus.perf_stall[j] = perf_cnt[j];
    end
  end
`else
  always_comb begin
    for (int unsigned j = 0; j < INPUTS; j++) begin
      bus.perf_stall[j] = '0;
    end
  end
`endif
endmodule

// File: tb/tb_crossbar_rr.sv
// tb_crossbar_rr: randomized bench for crossbar_rr with a transaction-level
// reference model (round-robin pointers as integers, credits as counts,
// in-flight reads and responses as queues). Outputs are compared 2 time
// units after inputs change, well away from the rising edge.
module tb_crossbar_rr;
  localparam int unsigned INPUTS = 4;
  localparam int unsigned BANKS  = 32;
  localparam int unsigned IAW    = 16;
  localparam int unsigned DW     = 32;
  localparam int unsigned ML     = 2;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned BB     = 5;
  localparam int          NCYC   = 3000;

  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  crossbar_rr_if #(.INPUTS(INPUTS), .BANKS(BANKS), .IADDR_WIDTH(IAW), .DATA_WIDTH(DW)) bus ();

  crossbar_rr #(
    .INPUTS(INPUTS), .BANKS(BANKS), .IADDR_WIDTH(IAW), .DATA_WIDTH(DW),
    .MEM_LATENCY(ML), .RD_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .srst(srst), .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // stimulus
  logic           s_srst;
  logic           s_valid  [INPUTS];
  logic [IAW-1:0] s_addr   [INPUTS];
  logic [DW-1:0]  s_data   [INPUTS];
  logic           s_we     [INPUTS];
  logic           s_oready [INPUTS];
  logic           s_iready [BANKS];
  logic [DW-1:0]  cur_mem  [BANKS];

  // reference model
  typedef struct { int due; int bank; } fl_t;
  int            rr      [BANKS];
  int            credit  [INPUTS];
  logic [31:0]   perf    [INPUTS];
  fl_t           infl    [INPUTS][$];
  logic [DW-1:0] rsp     [INPUTS][$];
  logic [DW-1:0] last_rsp[INPUTS];
  bit            popped  [INPUTS];
  int            cyc;

  // per-cycle expectations
  bit g_valid [BANKS];
  int g_idx   [BANKS];
  bit e_ready [INPUTS];
  bit acc_rd  [INPUTS];
  bit do_pop  [INPUTS];
  int bank_of [INPUTS];

  task automatic model_reset();
    for (int b = 0; b < BANKS; b++) rr[b] = 0;
    for (int j = 0; j < INPUTS; j++) begin
      credit[j] = 0;
      perf[j]   = 0;
      infl[j].delete();
      rsp[j].delete();
      last_rsp[j] = '0;
      popped[j]   = 1'b0;
    end
  endtask

  task automatic drive();
    srst = s_srst;
    for (int j = 0; j < INPUTS; j++) begin
      bus.t_valid[j]         = s_valid[j];
      bus.t_addr[j]          = s_addr[j];
      bus.t_data[j]          = s_data[j];
      bus.t_we[j]            = s_we[j];
      bus.i_dma_out_ready[j] = s_oready[j];
    end
    for (int b = 0; b < BANKS; b++) begin
      bus.i_ready[b]    = s_iready[b];
      bus.t_mem_data[b] = cur_mem[b];
    end
  endtask

  task automatic gen_stim(input int n);
    int ph;
    int bk;
    ph = (n / 250) % 4;
    s_srst = (n == 600 || n == 1000 || n == 1777 || n == 2400);
    for (int b = 0; b < BANKS; b++) begin
      s_iready[b] = ($urandom_range(0, 99) < 85);
      cur_mem[b]  = $urandom;
    end
    for (int j = 0; j < INPUTS; j++) begin
      s_data[j] = $urandom;
      case (ph)
        1: begin
          s_valid[j]  = ($urandom_range(0, 99) < 80);
          bk          = $urandom_range(0, 7);
          s_we[j]     = ($urandom_range(0, 99) < 20);
          s_oready[j] = 1'b0;
        end
        2: begin
          s_valid[j]  = (j == 2) ? ($urandom_range(0, 1) == 1) : 1'b1;
          bk          = 5;
          s_we[j]     = 1'b1;
          s_oready[j] = 1'b1;
        end
        3: begin
          s_valid[j]  = ($urandom_range(0, 99) < 75);
          bk          = ($urandom_range(0, 1) == 1) ? 7 : 8;
          s_we[j]     = ($urandom_range(0, 99) < 40);
          s_oready[j] = ($urandom_range(0, 99) < 60);
        end
        default: begin
          s_valid[j]  = ($urandom_range(0, 99) < 70);
          bk          = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, BANKS - 1);
          s_we[j]     = ($urandom_range(0, 99) < 40);
          s_oready[j] = ($urandom_range(0, 99) < 60);
        end
      endcase
      s_addr[j] = {IAW'($urandom) >> BB, BB'(bk)};
    end
    if (ph == 2) for (int b = 0; b < BANKS; b++) s_iready[b] = 1'b1;
    if (ph == 3) s_iready[7] = 1'b0;
  endtask

  task automatic compare_and_record();
    int j;
    int bk;
    logic [IAW-1:0] a;
    for (int b = 0; b < BANKS; b++) begin
      g_valid[b] = 1'b0;
      g_idx[b]   = 0;
      if (!s_srst) begin
        for (int k = 0; k < INPUTS; k++) begin
          j = (rr[b] + k) % INPUTS;
          if (!g_valid[b] && s_valid[j] && (int'(s_addr[j]) % BANKS == b) &&
              (s_we[j] || credit[j] < DEPTH)) begin
            g_valid[b] = 1'b1;
            g_idx[b]   = j;
          end
        end
      end
    end
    for (int b = 0; b < BANKS; b++) begin
      a = s_addr[g_idx[b]];
      check($sformatf("i_valid[%0d]", b), 64'(bus.i_valid[b]), 64'(g_valid[b]));
      check($sformatf("i_addr[%0d]", b), 64'(bus.i_addr[b]), g_valid[b] ? 64'(a >> BB) : 64'd0);
      check($sformatf("i_data[%0d]", b), 64'(bus.i_data[b]), g_valid[b] ? 64'(s_data[g_idx[b]]) : 64'd0);
      check($sformatf("i_we[%0d]", b), 64'(bus.i_we[b]), g_valid[b] ? 64'(s_we[g_idx[b]]) : 64'd0);
    end
    for (int i = 0; i < INPUTS; i++) begin
      bk = int'(s_addr[i]) % BANKS;
      bank_of[i] = bk;
      e_ready[i] = g_valid[bk] && (g_idx[bk] == i) && s_iready[bk];
      check($sformatf("t_ready[%0d]", i), 64'(bus.t_ready[i]), 64'(e_ready[i]));
      check($sformatf("dma_valid[%0d]", i), 64'(bus.i_dma_out_valid[i]), 64'(rsp[i].size() > 0));
      if (rsp[i].size() > 0)
        check($sformatf("dma_data[%0d]", i), 64'(bus.i_dma_out_data[i]), 64'(rsp[i][0]));
      else if (popped[i])
        check($sformatf("dma_hold[%0d]", i), 64'(bus.i_dma_out_data[i]), 64'(last_rsp[i]));
`ifdef CROSSBAR_RR_PERF_EN
      check($sformatf("perf_stall[%0d]", i), 64'(bus.perf_stall[i]), 64'(perf[i]));
`else
      check($sformatf("perf_stall[%0d]", i), 64'(bus.perf_stall[i]), 64'd0);
`endif
      acc_rd[i] = e_ready[i] && !s_we[i];
      do_pop[i] = (rsp[i].size() > 0) && s_oready[i];
      if (s_valid[i] && !e_ready[i] && perf[i] != 32'hFFFF_FFFF) perf[i]++;
    end
  endtask

  task automatic model_step();
    fl_t e;
    if (s_srst) begin
      model_reset();
    end else begin
      for (int j = 0; j < INPUTS; j++) begin
        if (do_pop[j]) begin
          last_rsp[j] = rsp[j].pop_front();
          popped[j]   = 1'b1;
        end
        while (infl[j].size() > 0 && infl[j][0].due == cyc) begin
          e = infl[j].pop_front();
          rsp[j].push_back(cur_mem[e.bank]);
        end
        if (acc_rd[j]) begin
          e.due  = cyc + ML;
          e.bank = bank_of[j];
          infl[j].push_back(e);
        end
        credit[j] = credit[j] + int'(acc_rd[j]) - int'(do_pop[j]);
      end
      for (int b = 0; b < BANKS; b++)
        if (g_valid[b] && s_iready[b]) rr[b] = (g_idx[b] + 1) % INPUTS;
    end
    cyc++;
  endtask

  initial begin
    cyc = 0;
    s_srst = 1'b1;
    for (int j = 0; j < INPUTS; j++) begin
      s_valid[j] = 1'b0; s_addr[j] = '0; s_data[j] = '0; s_we[j] = 1'b0; s_oready[j] = 1'b0;
    end
    for (int b = 0; b < BANKS; b++) begin
      s_iready[b] = 1'b0; cur_mem[b] = '0;
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    for (int n = 0; n < NCYC; n++) begin
      gen_stim(n);
      drive();
      #2;
      compare_and_record();
      @(posedge clk);
      model_step();
      #1;
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
